// File: rtl/mmu_req_arbiter.sv
// Round-robin arbiter sharing one MMU translation port among NumReq requesters.
// Optional BUSY watchdog is enabled by defining MMU_REQ_ARB_TIMEOUT_EN.
module mmu_req_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 255,
    parameter int unsigned VLEN          = 39,
    parameter int unsigned PLEN          = 56,
    parameter int unsigned ExWidth       = 129
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumReq-1:0]                req_i,
    input  logic [NumReq-1:0][VLEN-1:0]      vaddr_i,
    input  logic [NumReq-1:0]                is_store_i,
    input  logic [NumReq-1:0][ExWidth-1:0]   misaligned_ex_i,
    output logic [NumReq-1:0]                valid_o,
    output logic [PLEN-1:0]                  paddr_o,
    output logic [ExWidth-1:0]               exception_o,
    output logic [NumReq-1:0]                timeout_o,
    output logic                             busy_o,
    output logic                             acc_mmu_req_o,
    output logic [VLEN-1:0]                  acc_mmu_vaddr_o,
    output logic                             acc_mmu_is_store_o,
    output logic [ExWidth-1:0]               acc_mmu_misaligned_ex_o,
    input  logic                             acc_mmu_valid_i,
    input  logic [PLEN-1:0]                  acc_mmu_paddr_i,
    input  logic [ExWidth-1:0]               acc_mmu_exception_i
);

    localparam int unsigned RrW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [RrW-1:0] LastIdx = RrW'(NumReq - 1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_e;

    state_e               state_q, state_d;
    logic [RrW-1:0]       rr_q, rr_d;
    logic [RrW-1:0]       gnt_q, gnt_d;
    logic [NumReq-1:0]    mask_q, mask_d;
    logic [VLEN-1:0]      vaddr_q, vaddr_d;
    logic                 is_store_q, is_store_d;
    logic [ExWidth-1:0]   mis_ex_q, mis_ex_d;

    logic [NumReq-1:0]    gnt_oh;
    logic [NumReq-1:0]    eligible;
    logic                 active;
    logic                 complete;
    logic                 tmo_hit;
    logic                 done;
    logic                 found;
    int unsigned          idx;

    // Outputs are gated by reset so they read 0 even before the first clock edge.
    assign active   = rst_ni && (state_q == BUSY);
    assign complete = active && acc_mmu_valid_i;
    assign done     = complete || tmo_hit;

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_gnt_oh
        assign gnt_oh[gi] = (gnt_q == RrW'(gi));
    end

`ifdef MMU_REQ_ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    // Counter restarts every time the FSM is outside BUSY, so it is 0 on BUSY entry.
    always_comb begin
        cnt_d = '0;
        if (state_q == BUSY) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tmo_hit   = active && !acc_mmu_valid_i && (cnt_q == CntW'(TimeoutCycles));
    assign timeout_o = gnt_oh & {NumReq{tmo_hit}};
`else
    assign tmo_hit   = 1'b0;
    assign timeout_o = '0;
`endif

    assign valid_o                 = gnt_oh & {NumReq{done}};
    assign paddr_o                 = complete ? acc_mmu_paddr_i : '0;
    assign exception_o             = complete ? acc_mmu_exception_i : '0;
    assign busy_o                  = active;
    assign acc_mmu_req_o           = active;
    assign acc_mmu_vaddr_o         = active ? vaddr_q : '0;
    assign acc_mmu_is_store_o      = active && is_store_q;
    assign acc_mmu_misaligned_ex_o = active ? mis_ex_q : '0;

    assign eligible = req_i & ~mask_q;

    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        gnt_d      = gnt_q;
        mask_d     = '0;
        vaddr_d    = vaddr_q;
        is_store_d = is_store_q;
        mis_ex_d   = mis_ex_q;
        found      = 1'b0;
        idx        = 0;
        case (state_q)
            IDLE: begin
                // Search upward from rr_q with wrap; the first eligible requester wins.
                for (int unsigned i = 0; i < NumReq; i++) begin
                    idx = 32'(rr_q) + i;
                    if (idx >= NumReq) begin
                        idx = idx - NumReq;
                    end
                    if (!found && eligible[idx]) begin
                        found      = 1'b1;
                        gnt_d      = RrW'(idx);
                        vaddr_d    = vaddr_i[idx];
                        is_store_d = is_store_i[idx];
                        mis_ex_d   = misaligned_ex_i[idx];
                        state_d    = BUSY;
                    end
                end
            end
            BUSY: begin
                if (done) begin
                    state_d = IDLE;
                    mask_d  = gnt_oh;
                    rr_d    = (gnt_q == LastIdx) ? '0 : gnt_q + RrW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            rr_q       <= '0;
            gnt_q      <= '0;
            mask_q     <= '0;
            vaddr_q    <= '0;
            is_store_q <= 1'b0;
            mis_ex_q   <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            gnt_q      <= gnt_d;
            mask_q     <= mask_d;
            vaddr_q    <= vaddr_d;
            is_store_q <= is_store_d;
            mis_ex_q   <= mis_ex_d;
        end
    end

endmodule
